// File: rtl/logic_op_explorer.sv
// Logic-operation lab block: debounced keys pick one of eight bitwise ops on switch
// or sweep-counter operands; the registered result drives the LEDs with an identity self-check.
module logic_op_explorer #(
    parameter int clk_mhz      = 50,
    parameter int w_key        = 4,
    parameter int w_sw         = 8,
    parameter int w_led        = 8,
    parameter int debounce_cyc = clk_mhz * 10000,
    parameter int sweep_cyc    = clk_mhz * 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] key,
    input  logic [w_sw-1:0]  sw,
    output logic [w_led-1:0] led,
    output logic [2:0]       op_sel,
    output logic             sweep_active,
    output logic             check_ok
);

    localparam int w_op  = w_sw / 2;
    localparam int w_dbc = $clog2(debounce_cyc + 1);
    localparam int w_pre = $clog2(sweep_cyc + 1);

    localparam logic [w_dbc-1:0] dbc_last = w_dbc'(debounce_cyc - 1);
    localparam logic [w_pre-1:0] pre_last = w_pre'(sweep_cyc - 1);

    logic [w_key-1:0]  key_s1;
    logic [w_key-1:0]  key_s2;
    logic [w_key-1:0]  key_deb;
    logic [2:0]        key_deb_q;
    logic [w_dbc-1:0]  dbc_cnt [w_key];
    logic [2:0]        press;
    logic              freeze;

    logic [2*w_op-1:0] sweep_cnt;
    logic [w_pre-1:0]  pre_cnt;

    logic [2*w_op-1:0] opd_p0;
    logic [w_op-1:0]   a_p0;
    logic [w_op-1:0]   b_p0;

    function automatic logic [w_op-1:0] op_apply(input logic [2:0] op,
                                                 input logic [w_op-1:0] a,
                                                 input logic [w_op-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return ~a;
        endcase
    endfunction

    // Zero-extends or truncates the op result to the LED width.
    function automatic logic [w_led-1:0] fit_led(input logic [w_op-1:0] r);
        logic [w_led+w_op-1:0] ext;
        ext = {{w_led{1'b0}}, r};
        return ext[w_led-1:0];
    endfunction

    // Key synchroniser and per-key debounce: a run of debounce_cyc samples differing
    // from the debounced state commits the new level; any agreeing sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1    <= '0;
            key_s2    <= '0;
            key_deb   <= '0;
            key_deb_q <= '0;
            for (int i = 0; i < w_key; i++) dbc_cnt[i] <= '0;
        end else begin
            key_s1    <= key;
            key_s2    <= key_s1;
            key_deb_q <= key_deb[2:0];
            for (int i = 0; i < w_key; i++) begin
                if (key_s2[i] == key_deb[i]) begin
                    dbc_cnt[i] <= '0;
                end else if (dbc_cnt[i] == dbc_last) begin
                    dbc_cnt[i] <= '0;
                    key_deb[i] <= key_s2[i];
                end else begin
                    dbc_cnt[i] <= dbc_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = key_deb[2:0] & ~key_deb_q;

    generate
        if (w_key >= 4) begin : g_freeze
            assign freeze = key_deb[3];
        end else begin : g_no_freeze
            assign freeze = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sel       <= 3'd0;
            sweep_active <= 1'b0;
            sweep_cnt    <= '0;
            pre_cnt      <= '0;
        end else begin
            if (press[0] && !press[1])
                op_sel <= op_sel + 3'd1;
            else if (press[1] && !press[0])
                op_sel <= op_sel - 3'd1;

            if (press[2]) begin
                sweep_active <= ~sweep_active;
                sweep_cnt    <= '0;
                pre_cnt      <= '0;
            end else if (sweep_active) begin
                if (pre_cnt == pre_last) begin
                    pre_cnt   <= '0;
                    sweep_cnt <= sweep_cnt + 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p0: operand capture, held while key[3] freezes it.
    always_ff @(posedge clk) begin
        if (!freeze)
            opd_p0 <= sweep_active ? sweep_cnt : sw[2*w_op-1:0];
    end

    assign a_p0 = opd_p0[w_op-1:0];
    assign b_p0 = opd_p0[2*w_op-1:w_op];

    // Stage p1: registered result and sticky identity check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= '0;
            check_ok <= 1'b1;
        end else begin
            led <= fit_led(op_apply(op_sel, a_p0, b_p0));
            if ((~(a_p0 & b_p0) != (~a_p0 | ~b_p0)) ||
                (~(a_p0 | b_p0) != (~a_p0 & ~b_p0)) ||
                (((a_p0 | b_p0) & ~(a_p0 & b_p0)) != (a_p0 ^ b_p0)))
                check_ok <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_op_explorer.sv
// Directed bench for logic_op_explorer with small debounce/sweep timings.
module tb_logic_op_explorer;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic [7:0] sw;
    logic [7:0] led;
    logic [2:0] op_sel;
    logic       sweep_active;
    logic       check_ok;

    int errors = 0;
    int checks = 0;
    int exp_op = 0;

    logic_op_explorer #(
        .clk_mhz(50), .w_key(4), .w_sw(8), .w_led(8),
        .debounce_cyc(4), .sweep_cyc(8)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .sw(sw), .led(led),
        .op_sel(op_sel), .sweep_active(sweep_active), .check_ok(check_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        key[k] = 1'b1;
        tick(10);
        key[k] = 1'b0;
        tick(10);
    endtask

    function automatic logic [7:0] ref_led(input int op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~(a & b);
            4: r = ~(a | b);
            5: r = ~(a ^ b);
            6: r = a & ~b;
            default: r = ~a;
        endcase
        return {4'h0, r};
    endfunction

    task automatic goto_op(input int target);
        int n;
        n = (target - exp_op + 8) % 8;
        repeat (n) press(0);
        exp_op = target;
        chk("goto_op", op_sel, target);
    endtask

    initial begin
        logic [7:0] cnt;
        rst = 1'b1;
        key = '0;
        sw  = 8'h00;
        tick(3);
        chk("rst_led", led, 8'h00);
        chk("rst_op", op_sel, 3'd0);
        chk("rst_sweep", sweep_active, 1'b0);
        chk("rst_chk", check_ok, 1'b1);
        rst = 1'b0;

        // Basic ops on b=5, a=C
        sw = 8'h5C;
        tick(3);
        chk("and_5c", led, 8'h04);
        press(0);
        press(0);
        exp_op = 2;
        chk("op_inc2", op_sel, 3'd2);
        chk("xor_5c", led, 8'h09);
        press(1);
        press(1);
        chk("op_back0", op_sel, 3'd0);
        press(1);
        press(1);
        press(1);
        exp_op = 5;
        chk("op_dec3", op_sel, 3'd5);
        chk("xnor_5c", led, 8'h06);

        // Bounce rejection, then one clean press
        for (int r = 0; r < 3; r++) begin
            key[0] = 1'b1;
            tick(3);
            key[0] = 1'b0;
            tick(3);
        end
        tick(6);
        chk("bounce_noop", op_sel, 3'd5);
        key[0] = 1'b1;
        tick(6);
        key[0] = 1'b0;
        tick(12);
        exp_op = 6;
        chk("stable_inc", op_sel, 3'd6);
        chk("andn_5c", led, 8'h08);

        key[0] = 1'b1;
        key[1] = 1'b1;
        tick(10);
        key[0] = 1'b0;
        key[1] = 1'b0;
        tick(10);
        chk("both_keys", op_sel, 3'd6);

        // Press-to-op_sel latency: 2 sync + 4 debounce + 1
        key[0] = 1'b1;
        tick(6);
        chk("lat_before", op_sel, 3'd6);
        tick(1);
        chk("lat_at", op_sel, 3'd7);
        chk("led_lag", led, 8'h08);
        tick(1);
        chk("led_after", led, 8'h03);
        key[0] = 1'b0;
        tick(10);
        exp_op = 7;

        // Freeze operands with key[3]
        key[3] = 1'b1;
        tick(10);
        sw = 8'hFF;
        tick(3);
        chk("frz_hold", led, ref_led(7, 4'hC, 4'h5));
        press(0);
        exp_op = 0;
        chk("frz_op", op_sel, 3'd0);
        chk("frz_newop", led, ref_led(0, 4'hC, 4'h5));
        key[3] = 1'b0;
        tick(10);
        chk("frz_release", led, ref_led(0, 4'hF, 4'hF));
        sw = 8'h5C;
        tick(3);

        // Full sweep at every op, including wrap back to 0
        for (int op = 0; op < 8; op++) begin
            goto_op((op + 1) % 8);
            key[2] = 1'b1;
            tick(6);
            chk("sweep_pre", sweep_active, 1'b0);
            tick(1);
            chk("sweep_on", sweep_active, 1'b1);
            key[2] = 1'b0;
            tick(2);
            for (int s = 0; s <= 256; s++) begin
                tick(4);
                cnt = s[7:0];
                chk("sweep_led", led, ref_led(exp_op, cnt[3:0], cnt[7:4]));
                tick(4);
            end
            key[2] = 1'b1;
            tick(7);
            chk("sweep_off", sweep_active, 1'b0);
            key[2] = 1'b0;
            tick(10);
            chk("sw_restore", led, ref_led(exp_op, 4'hC, 4'h5));
        end
        chk("check_ok", check_ok, 1'b1);

        // Asynchronous reset in the middle of a sweep
        key[2] = 1'b1;
        tick(7);
        key[2] = 1'b0;
        tick(20);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_op", op_sel, 3'd0);
        chk("arst_sweep", sweep_active, 1'b0);
        chk("arst_chk", check_ok, 1'b1);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst", led, 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
